// File: rtl/controller_v2.sv
// Multicycle core sequencer: fetch/decode/execute/mem/writeback with ready/valid
// memory handshakes, per-phase timeout watchdogs, sticky errors and a retire counter.
module controller_v2 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int ERR_W   = 8,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [6:0]         instr_opcode,
    output logic               dmem_req_valid,
    output logic               dmem_req_we,
    input  logic               dmem_req_ready,
    input  logic               dmem_rsp_valid,
    output logic               ir_we,
    output logic               pc_we,
    output logic               rf_we,
    output logic               busy,
    output logic               trap,
    input  logic               err_clr,
    output logic [ERR_W-1:0]   err_vector,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [3:0] {
        S_INIT       = 4'd0,
        S_IDLE       = 4'd1,
        S_FETCH      = 4'd2,
        S_FETCH_WAIT = 4'd3,
        S_DECODE     = 4'd4,
        S_EXECUTE    = 4'd5,
        S_MEM        = 4'd6,
        S_MEM_WAIT   = 4'd7,
        S_WRITEBACK  = 4'd8,
        S_TRAP       = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // One spare bit: a handshake won on the last FETCH cycle carries the count
    // into FETCH_WAIT past TIMEOUT-1, which must still trip the watchdog there.
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t         state, next_state;
    logic [6:0]     opcode_q;
    logic [TW-1:0]  tcnt;
    logic [3:0]     err_q, err_set;
    logic           in_phase, timeout_hit, op_legal, op_mem;

    assign in_phase    = (state == S_FETCH) || (state == S_FETCH_WAIT) ||
                         (state == S_MEM)   || (state == S_MEM_WAIT);
    assign timeout_hit = (tcnt >= TW'(TIMEOUT - 1));
    assign op_mem      = (opcode_q == OP_LOAD) || (opcode_q == OP_STORE);

    always_comb begin
        op_legal = 1'b0;
        case (opcode_q)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    end

    // Next-state logic; a completed handshake always takes priority over timeout.
    always_comb begin
        next_state = state;
        err_set    = 4'b0000;
        case (state)
            S_INIT: next_state = S_IDLE;
            S_IDLE: if (start) next_state = S_FETCH;
            S_FETCH: begin
                if (imem_req_ready) next_state = S_FETCH_WAIT;
                else if (timeout_hit) begin
                    err_set[1] = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_FETCH_WAIT: begin
                if (imem_rsp_valid) next_state = S_DECODE;
                else if (timeout_hit) begin
                    err_set[1] = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                if (op_legal) next_state = S_EXECUTE;
                else begin
                    err_set[0] = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_EXECUTE: next_state = op_mem ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                if (dmem_req_ready) next_state = S_MEM_WAIT;
                else if (timeout_hit) begin
                    err_set[2] = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid) next_state = S_WRITEBACK;
                else if (timeout_hit) begin
                    err_set[2] = 1'b1;
                    next_state = S_TRAP;
                end
            end
            S_WRITEBACK: next_state = halt_req ? S_IDLE : S_FETCH;
            S_TRAP: if (err_clr) next_state = S_IDLE;
            default: begin
                err_set[3] = 1'b1;
                next_state = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_INIT;
            opcode_q    <= '0;
            tcnt        <= '0;
            err_q       <= '0;
            retired_cnt <= '0;
        end else begin
            state <= next_state;
            tcnt  <= in_phase ? tcnt + 1'b1 : '0;
            if (state == S_FETCH_WAIT && imem_rsp_valid)
                opcode_q <= instr_opcode;
            // Sticky flags: a new set in the same cycle as err_clr survives.
            err_q <= (err_clr ? 4'b0000 : err_q) | err_set;
            if (state == S_WRITEBACK)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

    // Valid/ready: a request is held while valid=1 and completes on the cycle
    // ready=1; a valid is never withdrawn except by reset or the watchdog.
    assign imem_req_valid = (state == S_FETCH);
    assign dmem_req_valid = (state == S_MEM);
    assign dmem_req_we    = (state == S_MEM) && (opcode_q == OP_STORE);
    assign ir_we          = (state == S_FETCH_WAIT) && imem_rsp_valid;
    assign pc_we          = (state == S_WRITEBACK);
    assign rf_we          = (state == S_WRITEBACK) &&
                            (opcode_q != OP_STORE) && (opcode_q != OP_BRANCH);
    assign busy           = (state != S_IDLE) && (state != S_TRAP);
    assign trap           = (state == S_TRAP);
    assign err_vector     = ERR_W'(err_q);
    assign state_o        = STATE_W'(state);

endmodule

// File: tb/tb_controller_v2.sv
// Directed bench for controller_v2: linear step sequence with immediate assertions.
module tb_controller_v2;

    logic        clk = 1'b0;
    logic        rst, start, halt_req, imem_req_ready, imem_rsp_valid;
    logic [6:0]  instr_opcode;
    logic        dmem_req_ready, dmem_rsp_valid, err_clr;
    logic        imem_req_valid, dmem_req_valid, dmem_req_we;
    logic        ir_we, pc_we, rf_we, busy, trap;
    logic [7:0]  err_vector;
    logic [3:0]  state_o;
    logic [31:0] retired_cnt;

    int vectors    = 0;
    int miscompares = 0;

    controller_v2 #(.TIMEOUT(16), .CNT_W(32), .ERR_W(8), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .instr_opcode(instr_opcode),
        .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .busy(busy), .trap(trap),
        .err_clr(err_clr), .err_vector(err_vector), .state_o(state_o),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; instr_opcode = 7'd0; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err", err_vector, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_ivalid", imem_req_valid, 0);
        rst = 1'b1;
        tick();
        chk("idle_state", state_o, 1);
        chk("idle_busy", busy, 0);

        // OP instruction
        start = 1'b1; tick(); start = 1'b0;
        chk("op_fetch", state_o, 2);
        chk("op_ivalid", imem_req_valid, 1);
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        chk("op_fwait", state_o, 3);
        chk("op_ivalid_low", imem_req_valid, 0);
        imem_rsp_valid = 1'b1; instr_opcode = 7'b0110011; #1;
        chk("op_ir_we", ir_we, 1);
        tick(); imem_rsp_valid = 1'b0; #1;
        chk("op_decode", state_o, 4);
        chk("op_ir_we_off", ir_we, 0);
        tick();
        chk("op_exec", state_o, 5);
        tick();
        chk("op_wb", state_o, 8);
        chk("op_pc_we", pc_we, 1);
        chk("op_rf_we", rf_we, 1);
        tick();
        chk("op_refetch", state_o, 2);
        chk("op_retired", retired_cnt, 1);

        // LOAD with dmem ready delayed three cycles
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; instr_opcode = 7'b0000011;
        tick(); imem_rsp_valid = 1'b0;
        tick(); tick();
        chk("ld_mem", state_o, 6);
        for (int i = 0; i < 3; i++) begin
            chk("ld_dvalid_hold", dmem_req_valid, 1);
            chk("ld_we", dmem_req_we, 0);
            tick();
        end
        chk("ld_dvalid_4th", dmem_req_valid, 1);
        dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
        chk("ld_mwait", state_o, 7);
        chk("ld_dvalid_low", dmem_req_valid, 0);
        dmem_rsp_valid = 1'b1; tick(); dmem_rsp_valid = 1'b0;
        chk("ld_wb", state_o, 8);
        chk("ld_rf_we", rf_we, 1);
        tick();
        chk("ld_retired", retired_cnt, 2);

        // STORE, halting in writeback
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; instr_opcode = 7'b0100011;
        tick(); imem_rsp_valid = 1'b0;
        tick(); tick();
        chk("st_mem", state_o, 6);
        chk("st_we", dmem_req_we, 1);
        chk("st_ivalid", imem_req_valid, 0);
        dmem_req_ready = 1'b1; tick(); dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1; tick(); dmem_rsp_valid = 1'b0;
        chk("st_wb", state_o, 8);
        chk("st_rf_we", rf_we, 0);
        chk("st_pc_we", pc_we, 1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_idle", state_o, 1);
        chk("halt_retired", retired_cnt, 3);

        // Illegal opcode (SYSTEM)
        start = 1'b1; tick(); start = 1'b0;
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; instr_opcode = 7'b1110011;
        tick(); imem_rsp_valid = 1'b0;
        tick();
        chk("ill_trap_state", state_o, 9);
        chk("ill_trap", trap, 1);
        chk("ill_err", err_vector, 8'h01);
        chk("ill_busy", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("trap_ignores_start", state_o, 9);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_idle", state_o, 1);
        chk("clr_err", err_vector, 0);
        chk("clr_trap", trap, 0);

        // Fetch timeout: no ready at all
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("ito_last_fetch", state_o, 2);
        tick();
        chk("ito_trap", state_o, 9);
        chk("ito_err", err_vector, 8'h02);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ito_clr", err_vector, 0);

        // Ready on the 16th fetch cycle wins over the timeout
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        chk("race_fwait", state_o, 3);
        chk("race_err", err_vector, 0);
        chk("race_trap", trap, 0);
        imem_rsp_valid = 1'b1; instr_opcode = 7'b0000011;
        tick(); imem_rsp_valid = 1'b0;
        tick(); tick();
        chk("rst_mid_mem", state_o, 6);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst_mid_state", state_o, 0);
        chk("rst_mid_dvalid", dmem_req_valid, 0);
        chk("rst_mid_cnt", retired_cnt, 0);

        // Data-phase timeout
        tick();
        start = 1'b1; tick(); start = 1'b0;
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; instr_opcode = 7'b0100011;
        tick(); imem_rsp_valid = 1'b0;
        tick(); tick();
        chk("dto_mem", state_o, 6);
        for (int i = 0; i < 15; i++) tick();
        chk("dto_last_mem", state_o, 6);
        tick();
        chk("dto_trap", state_o, 9);
        chk("dto_err", err_vector, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
